// File: rtl/bch_15_7_pkg.sv
// Shared BCH(15,7) constants, encoder state type and the single-step LFSR update
// used by both the parity register and the encoder's final-step lookahead.
package bch_15_7_pkg;

    localparam int unsigned BCH_N        = 15;
    localparam int unsigned BCH_K        = 7;
    localparam int unsigned BCH_PAR_W    = 8;
    localparam logic [8:0]  BCH_GEN_POLY = 9'h1D1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } bch_enc_state_t;

    // One MSB-first division step of d(x)*x^8 by g(x); gen excludes the x^8 term.
    function automatic logic [BCH_PAR_W-1:0] bch_par_step(
        input logic [BCH_PAR_W-1:0] par,
        input logic                 b,
        input logic [BCH_PAR_W-1:0] gen
    );
        logic fb;
        fb = b ^ par[BCH_PAR_W-1];
        return {par[BCH_PAR_W-2:0], 1'b0} ^ (fb ? gen : '0);
    endfunction

endpackage

// File: rtl/bch_15_7_parity_lfsr.sv
// 8-bit Galois LFSR accumulating BCH(15,7) parity one data bit per enabled clock.
module bch_15_7_parity_lfsr
    import bch_15_7_pkg::*;
#(
    parameter logic [7:0] GEN_POLY = 8'hD1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] par
);

    logic [7:0] par_q;
    logic [7:0] par_d;

    always_comb begin
        par_d = par_q;
        if (clr) begin
            par_d = '0;
        end else if (en) begin
            par_d = bch_par_step(par_q, bit_in, GEN_POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;

endmodule

// File: rtl/bch_15_7_serial_encoder.sv
// Bit-serial systematic BCH(15,7) encoder with valid/ready on both sides.
// Optional macro BCH_ENC_ERR_INJECT_EN adds an err_mask port XORed onto the output codeword.
module bch_15_7_serial_encoder
    import bch_15_7_pkg::*;
#(
    parameter int unsigned N        = BCH_N,
    parameter int unsigned K        = BCH_K,
    parameter logic [7:0]  GEN_POLY = 8'hD1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_codeword,
    output logic         out_valid,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [N-1:0] err_mask,
`endif
    input  logic         out_ready
);

    localparam logic [2:0] K_M1 = 3'(K - 1);

    bch_enc_state_t state_q, state_d;
    logic [K-1:0]   data_q, data_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [N-1:0]   out_cw_q, out_cw_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   err_q, err_d;

    logic           accept;
    logic           shifting;
    logic [2:0]     bit_idx;
    logic           bit_cur;
    logic [7:0]     par;
    logic [7:0]     next_par;
    logic [N-1:0]   clean_cw;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shifting = (state_q == SHIFT);
    assign bit_idx  = K_M1 - cnt_q;
    assign bit_cur  = data_q[bit_idx];

    bch_15_7_parity_lfsr #(
        .GEN_POLY (GEN_POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (shifting),
        .bit_in (bit_cur),
        .par    (par)
    );

    // Last shift stores the LFSR's next value directly, saving a cycle before OUT.
    assign next_par = bch_par_step(par, bit_cur, GEN_POLY);
    assign clean_cw = {data_q, next_par};

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        out_cw_d    = out_cw_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = '0;
`ifdef BCH_ENC_ERR_INJECT_EN
                    err_d   = err_mask;
`else
                    err_d   = '0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == K_M1) begin
                    out_cw_d    = clean_cw ^ err_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            out_cw_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            out_cw_q    <= out_cw_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_codeword = out_cw_q;
    assign out_valid    = out_valid_q;

endmodule
